// File: rtl/param_seq_detector_pkg.sv
// Shared constants for the parametrised sequence detector.
//   SEQ_LEN_MIN/MAX : legal pattern-length range
//   CNT_W_MIN/MAX   : legal match-counter width range
//   PAT_11110       : reset pattern, the legacy fixed-detector sequence
package seq_det_pkg;

  localparam int SEQ_LEN_MIN = 2;
  localparam int SEQ_LEN_MAX = 16;
  localparam int CNT_W_MIN   = 4;
  localparam int CNT_W_MAX   = 32;

  localparam logic [4:0] PAT_11110 = 5'b11110;

endpackage

// File: rtl/param_seq_detector_if.sv
// Bus bundle between a serial bit source and the sequence detector.
//   master : drives din/din_valid/overlap/pat_load/pat_in/count_clr,
//            observes det_out/match_count/pattern
//   slave  : the detector side
interface param_seq_detector_if #(
  parameter int SEQ_LEN = 5,
  parameter int CNT_W   = 16
);
  logic               din;
  logic               din_valid;
  logic               overlap;
  logic               pat_load;
  logic [SEQ_LEN-1:0] pat_in;
  logic               count_clr;
  logic               det_out;
  logic [CNT_W-1:0]   match_count;
  logic [SEQ_LEN-1:0] pattern;

  modport master (
    output din, din_valid, overlap, pat_load, pat_in, count_clr,
    input  det_out, match_count, pattern
  );

  modport slave (
    input  din, din_valid, overlap, pat_load, pat_in, count_clr,
    output det_out, match_count, pattern
  );
endinterface

// File: rtl/param_seq_detector_sat_counter.sv
// Saturating up-counter with clear.
//   clk, reset : rising-edge clock, synchronous active-low reset
//   clr_i      : clear; with inc_i in the same cycle the result is 1
//   inc_i      : increment, holds at all ones
//   count_o    : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      // a clear coinciding with an event keeps that event
      count_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/param_seq_detector.sv
// Serial pattern detector with runtime-loadable pattern.
//   clk, reset : rising-edge clock, synchronous active-low reset
//   bus        : slave side of param_seq_detector_if (bit stream, mode,
//                pattern load, count clear in; detect pulse, match count,
//                current pattern out)
//
// fill_q      | meaning
// ------------+------------------------------------------------------
// 0..SEQ_LEN-2| still collecting fresh bits, no compare made yet
// SEQ_LEN-1   | history full, every accepted bit is compared
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int                 SEQ_LEN     = 5,
  parameter logic [SEQ_LEN-1:0] DEFAULT_PAT = PAT_11110,
  parameter int                 CNT_W       = 16
) (
  input logic                 clk,
  input logic                 reset,
  param_seq_detector_if.slave bus
);
  localparam int FILL_W = $clog2(SEQ_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN - 1);

  if (SEQ_LEN < SEQ_LEN_MIN || SEQ_LEN > SEQ_LEN_MAX) begin : g_bad_len
    $error("param_seq_detector: SEQ_LEN out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt
    $error("param_seq_detector: CNT_W out of range");
  end

  logic [SEQ_LEN-1:0] pat_q, pat_d;
  logic [SEQ_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               det_q, det_d;
  logic [SEQ_LEN-1:0] cand;
  logic               match;
  logic [CNT_W-1:0]   count;

  assign cand  = {hist_q, bus.din};
  assign match = bus.din_valid && !bus.pat_load &&
                 (fill_q == FILL_FULL) && (cand == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = 1'b0;
    if (bus.pat_load) begin
      // a bit arriving with a load is dropped: it belongs to the old pattern
      pat_d  = bus.pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.din_valid) begin
      hist_d = cand[SEQ_LEN-2:0];
      det_d  = match;
      if (match)                  fill_d = bus.overlap ? FILL_FULL : '0;
      else if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q  <= DEFAULT_PAT;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (bus.count_clr),
    .inc_i   (match),
    .count_o (count)
  );

  assign bus.det_out     = det_q;
  assign bus.match_count = count;
  assign bus.pattern     = pat_q;
endmodule

// File: tb/tb_param_seq_detector.sv
module tb_param_seq_detector;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b0, din_valid = 1'b0, ov = 1'b0, pat_load = 1'b0, count_clr = 1'b0;
  logic [4:0] pat_in = 5'b0;
  int         n_pass = 0, n_total = 0;
  bit         started = 1'b0;

  always #5 clk = ~clk;

  param_seq_detector_if #(.SEQ_LEN(5), .CNT_W(16)) bus16 ();
  param_seq_detector_if #(.SEQ_LEN(5), .CNT_W(4))  bus4 ();

  assign bus16.din = din;       assign bus4.din = din;
  assign bus16.din_valid = din_valid; assign bus4.din_valid = din_valid;
  assign bus16.overlap = ov;    assign bus4.overlap = ov;
  assign bus16.pat_load = pat_load; assign bus4.pat_load = pat_load;
  assign bus16.pat_in = pat_in; assign bus4.pat_in = pat_in;
  assign bus16.count_clr = count_clr; assign bus4.count_clr = count_clr;

  param_seq_detector #(.SEQ_LEN(5), .DEFAULT_PAT(5'b11110), .CNT_W(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16.slave));
  param_seq_detector #(.SEQ_LEN(5), .DEFAULT_PAT(5'b11110), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave));

  // Model: keep the bits accepted since the last restart; a match is the last
  // five of them equal to the pattern.
  bit         m_bits[$];
  logic [4:0] m_pat = 5'b11110;
  int         m_det = 0, m_cnt16 = 0, m_cnt4 = 0;

  always @(posedge clk) begin
    int   hit;
    logic [4:0] v;
    hit = 0;
    if (!reset) begin
      m_pat = 5'b11110; m_bits.delete(); m_det = 0; m_cnt16 = 0; m_cnt4 = 0;
    end else begin
      if (pat_load) begin
        m_pat = pat_in; m_bits.delete();
      end else if (din_valid) begin
        m_bits.push_back(din);
        if (m_bits.size() > 5) void'(m_bits.pop_front());
        if (m_bits.size() == 5) begin
          v = '0;
          for (int i = 0; i < 5; i++) v = {v[3:0], m_bits[i]};
          if (v == m_pat) begin
            hit = 1;
            if (!ov) m_bits.delete();
          end
        end
      end
      m_det = hit;
      if (count_clr) begin
        m_cnt16 = hit; m_cnt4 = hit;
      end else if (hit != 0) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_det16", int'(bus16.det_out), m_det);
      chk("cyc_det4", int'(bus4.det_out), m_det);
      chk("cyc_cnt16", int'(bus16.match_count), m_cnt16);
      chk("cyc_cnt4", int'(bus4.match_count), m_cnt4);
      chk("cyc_pat16", int'(bus16.pattern), int'(m_pat));
      chk("cyc_pat4", int'(bus4.pattern), int'(m_pat));
    end
  end

  task automatic drive(input logic v, input logic d, input logic pl,
                       input logic [4:0] pi, input logic cc, input logic rst);
    @(negedge clk);
    din_valid = v; din = d; pat_load = pl; pat_in = pi; count_clr = cc; reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic d);
    drive(1'b1, d, 1'b0, 5'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b1);
  endtask

  task automatic load(input logic [4:0] p);
    drive(1'b0, 1'b0, 1'b1, p, 1'b0, 1'b1);
  endtask

  initial begin
    int stream[7] = '{1, 0, 1, 0, 1, 0, 1};
    int e_ov[7]   = '{0, 0, 0, 0, 1, 0, 1};
    int e_no[7]   = '{0, 0, 0, 0, 1, 0, 0};
    int pulses;

    drive(1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0);
    started = 1'b1;
    chk("rst_det", int'(bus16.det_out), 0);
    chk("rst_cnt", int'(bus16.match_count), 0);
    chk("rst_pat", int'(bus16.pattern), 5'b11110);

    // default pattern, non-overlap
    ov = 1'b0;
    send(1); send(1); send(1); send(1);
    chk("pre_pulse", int'(bus16.det_out), 0);
    send(0);
    chk("def_det", int'(bus16.det_out), 1);
    chk("def_cnt", int'(bus16.match_count), 1);
    idle();
    chk("def_one_cycle", int'(bus16.det_out), 0);
    send(1); send(1); send(1); send(0);
    chk("short_det", int'(bus16.det_out), 0);
    chk("short_cnt", int'(bus16.match_count), 1);

    // periodic pattern, overlap then non-overlap
    ov = 1'b1;
    load(5'b10101);
    chk("load_pat", int'(bus16.pattern), 5'b10101);
    for (int i = 0; i < 7; i++) begin
      send(stream[i][0]);
      chk("ov_det", int'(bus16.det_out), e_ov[i]);
    end
    chk("ov_cnt", int'(bus16.match_count), 3);
    ov = 1'b0;
    load(5'b10101);
    for (int i = 0; i < 7; i++) begin
      send(stream[i][0]);
      chk("noov_det", int'(bus16.det_out), e_no[i]);
    end
    chk("noov_cnt", int'(bus16.match_count), 4);

    // load coincident with a valid bit discards it
    load(5'b11110);
    send(1); send(1); send(1); send(1);
    drive(1'b1, 1'b1, 1'b1, 5'b11110, 1'b0, 1'b1);
    chk("discard_det", int'(bus16.det_out), 0);
    send(0);
    chk("discard_fresh", int'(bus16.det_out), 0);
    send(1); send(1); send(1); send(1); send(0);
    chk("refill_det", int'(bus16.det_out), 1);
    chk("refill_cnt", int'(bus16.match_count), 5);

    // valid gaps
    send(1); send(1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("gap_det", int'(bus16.det_out), 0);
    end
    send(1); send(1); send(0);
    chk("gap_pulse", int'(bus16.det_out), 1);
    chk("gap_cnt", int'(bus16.match_count), 6);

    // saturation on the 4-bit counter
    drive(1'b0, 1'b0, 1'b0, 5'b0, 1'b1, 1'b1);
    chk("clr_cnt", int'(bus4.match_count), 0);
    ov = 1'b1;
    load(5'b11111);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      send(1);
      pulses += int'(bus4.det_out);
    end
    chk("sat_pulses", pulses, 21);
    chk("sat_cnt4", int'(bus4.match_count), 15);
    chk("sat_cnt16", int'(bus16.match_count), 21);
    drive(1'b1, 1'b1, 1'b0, 5'b0, 1'b1, 1'b1);
    chk("clr_match_det", int'(bus4.det_out), 1);
    chk("clr_match_cnt4", int'(bus4.match_count), 1);
    chk("clr_match_cnt16", int'(bus16.match_count), 1);

    // reset mid-sequence
    ov = 1'b0;
    load(5'b11111);
    send(1); send(1); send(1); send(1);
    drive(1'b1, 1'b1, 1'b0, 5'b0, 1'b0, 1'b0);
    chk("mid_rst_det", int'(bus16.det_out), 0);
    chk("mid_rst_cnt", int'(bus16.match_count), 0);
    chk("mid_rst_pat", int'(bus16.pattern), 5'b11110);
    send(0);
    chk("post_rst_det", int'(bus16.det_out), 0);
    idle();

    started = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
